// File: rtl/mem_stage_lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_lsu_if
// Brief    : Data-memory request/acknowledge bus between the LSU and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_stage_lsu_if #(
    parameter int XLEN = 64
);
    logic                  dmem_req;
    logic                  dmem_we;
    logic [XLEN-1:0]       dmem_addr;
    logic [XLEN-1:0]       dmem_wdata;
    logic [XLEN/8-1:0]     dmem_wmask;
    logic                  dmem_ack;
    logic [XLEN-1:0]       dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
        output dmem_ack, dmem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_lsu
// Brief    : MEM-stage load/store unit: one 64-bit req/ack transaction per
//            load or store, with store lane masking and load extension.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_lsu #(
    parameter int XLEN = 64
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              mem_valid,
    input  wire logic              mem_read,
    input  wire logic              mem_write,
    input  wire logic [2:0]        mem_funct3,
    input  wire logic [XLEN-1:0]   mem_addr,
    input  wire logic [XLEN-1:0]   mem_wdata,
    mem_stage_lsu_if.master        dmem,
    output logic                   stall,
    output logic [XLEN-1:0]        load_data,
    output logic                   load_valid,
    output logic                   misaligned
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_req;
    logic                r_we;
    logic [2:0]          r_funct3;
    logic [2:0]          r_off;
    logic [XLEN-1:0]     r_addr;
    logic [XLEN-1:0]     r_wdata;
    logic [XLEN/8-1:0]   r_mask;
    logic [XLEN-1:0]     r_load_data;
    logic                r_load_valid;

    logic                w_start;
    logic                w_idle;
    logic                w_mis;
    logic                w_go;
    logic [2:0]          w_off;
    logic [XLEN/8-1:0]   w_mask_base;
    logic [XLEN-1:0]     w_rshift;
    logic [XLEN-1:0]     w_load_ext;

    assign w_start = mem_valid & (mem_read | mem_write);
    assign w_idle  = (r_state == ST_IDLE);
    assign w_off   = mem_addr[2:0];

    always_comb begin
        w_mis       = 1'b0;
        w_mask_base = 8'h01;
        case (mem_funct3[1:0])
            2'd0: begin w_mis = 1'b0;          w_mask_base = 8'h01; end
            2'd1: begin w_mis = w_off[0];      w_mask_base = 8'h03; end
            2'd2: begin w_mis = |w_off[1:0];   w_mask_base = 8'h0F; end
            default: begin w_mis = |w_off;     w_mask_base = 8'hFF; end
        endcase
    end

    assign w_go       = w_idle & w_start & ~w_mis;
    assign misaligned = w_idle & w_start & w_mis;
    // Stall must rise in the start cycle itself, before the request registers.
    assign stall      = w_go | (r_state == ST_REQ);

    assign w_rshift = dmem.dmem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_load_ext = w_rshift;
        case (r_funct3)
            3'b000:  w_load_ext = {{(XLEN-8){w_rshift[7]}},   w_rshift[7:0]};
            3'b001:  w_load_ext = {{(XLEN-16){w_rshift[15]}}, w_rshift[15:0]};
            3'b010:  w_load_ext = {{(XLEN-32){w_rshift[31]}}, w_rshift[31:0]};
            3'b100:  w_load_ext = {{(XLEN-8){1'b0}},          w_rshift[7:0]};
            3'b101:  w_load_ext = {{(XLEN-16){1'b0}},         w_rshift[15:0]};
            3'b110:  w_load_ext = {{(XLEN-32){1'b0}},         w_rshift[31:0]};
            default: w_load_ext = w_rshift;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_off        <= 3'b000;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mask       <= '0;
            r_load_data  <= '0;
            r_load_valid <= 1'b0;
        end else begin
            r_load_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        // A simultaneous read and write is resolved as a load.
                        r_we     <= mem_write & ~mem_read;
                        r_funct3 <= mem_funct3;
                        r_off    <= w_off;
                        r_addr   <= {mem_addr[XLEN-1:3], 3'b000};
                        r_wdata  <= mem_wdata << {w_off, 3'b000};
                        r_mask   <= w_mask_base << w_off;
                        r_req    <= 1'b1;
                        r_state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (dmem.dmem_ack) begin
                        r_req <= 1'b0;
                        if (!r_we) begin
                            r_load_data  <= w_load_ext;
                            r_load_valid <= 1'b1;
                        end
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_wdata = r_wdata;
    assign dmem.dmem_wmask = r_mask;
    assign load_data       = r_load_data;
    assign load_valid      = r_load_valid;

endmodule
`default_nettype wire

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

MEM-stage load/store unit that consumes the EX/MEM pipeline register outputs and drives the data-memory port. It converts one load or store per instruction into a single 64-bit request/acknowledge transaction, applying byte-lane masking for stores and sign or zero extension for loads. While a transaction is outstanding it stalls the upstream pipeline. It also flags misaligned accesses.

## Interface
Parameters:
- `XLEN`, default 64: data and address width. Only 64 is supported.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `mem_valid` in 1: the EX/MEM register holds a real instruction, not a bubble.
- `mem_read` in 1: load, from the M control bits.
- `mem_write` in 1: store, from the M control bits.
- `mem_funct3` in 3: `inst[14:12]`, selects size and signedness.
- `mem_addr` in 64: effective address, taken from the ALU result.
- `mem_wdata` in 64: store data, taken from the rs2 data.
- `dmem_req` out 1: request valid.
- `dmem_we` out 1: write enable.
- `dmem_addr` out 64: 8-byte-aligned address.
- `dmem_wdata` out 64: lane-shifted store data.
- `dmem_wmask` out 8: byte-enable mask.
- `dmem_ack` in 1: request accepted and completed.
- `dmem_rdata` in 64: read doubleword, valid when `dmem_ack` is high.
- `stall` out 1: holds the PC, IF/ID, ID/EX and EX/MEM registers.
- `load_data` out 64: extended load result for MEM/WB.
- `load_valid` out 1: `load_data` is valid this cycle.
- `misaligned` out 1: misaligned-access exception.

## Operation
- The FSM has three states: IDLE, REQ and DONE.
- Start condition: `start = mem_valid & (mem_read | mem_write)` while in IDLE.
  - If both `mem_read` and `mem_write` are high, the access is treated as a load.
- Access size comes from `funct3[1:0]`:
  - 0 = byte, 1 = half, 2 = word, 3 = double.
  - `funct3[2]` = 1 means zero-extend (LBU, LHU, LWU).
  - For stores, `funct3[2]` is ignored.
- An access is misaligned when `addr[size-1:0]` is not zero (for half, word and double).
  - Misaligned accesses issue no request and cause no stall.
  - `misaligned` is asserted combinationally in IDLE while the start condition holds.
- IDLE → REQ on an aligned start.
  - `stall` is asserted combinationally in that same cycle.
  - The unit latches `we`, `funct3`, `addr[2:0]`, `{addr[63:3],3'b000}`, the shifted store data and the mask.
- REQ:
  - `dmem_req` = 1. `dmem_we`, `dmem_addr`, `dmem_wdata` and `dmem_wmask` come from the latched values and stay stable until ack.
  - `stall` = 1.
  - On `dmem_ack`: the extended `dmem_rdata` is captured into `load_data` (loads only), and the FSM moves to DONE.
- DONE:
  - `stall` = 0.
  - `load_valid` = 1 for loads only.
  - The FSM always returns to IDLE; no start is evaluated in DONE.
  - The pipeline advances at the end of this cycle, so the same instruction is never reissued.
- Store mask: {1, 3, 0F, FF} for byte, half, word, double, shifted left by `addr[2:0]`.
- Store data: `mem_wdata << (8*addr[2:0])`.
- Load extraction: `dmem_rdata >> (8*addr[2:0])`, truncated to the access size, then sign- or zero-extended to 64 bits.
- `dmem_ack` is ignored in IDLE and DONE.
- `load_data` holds its value until the next load completes.

## Timing
- Reset values of all outputs:
  - `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `dmem_wmask`: 0.
  - `stall`, `load_data`, `load_valid`, `misaligned`: 0.
  - FSM state: IDLE.
- Minimum access, with ack in the first REQ cycle:
  - Cycle 0: IDLE with start, `stall` = 1.
  - Cycle 1: REQ with ack.
  - Cycle 2: DONE.
  - `stall` is high for 2 cycles.
- An ack delay of N cycles after `req` rises gives N+2 stall cycles.
- `dmem_req` is registered and never goes high in the same cycle as start.
- Back-to-back memory instructions: the next start is evaluated in the cycle after DONE. The minimum issue interval is 3 cycles.
- Reset asserted in REQ: `dmem_req` drops immediately (asynchronously) and the transaction is abandoned. After reset release the unit is in IDLE with `stall` = 0.
- A non-memory instruction or a bubble in IDLE: no outputs asserted, no state change.

## Test plan
- LW, addr `0x1004`, `dmem_rdata` `0x80000000_12345678`, ack in the first REQ cycle:
  - `dmem_addr` = `0x1000`.
  - `load_data` = `0xFFFFFFFF_80000000`, `load_valid` high in cycle 2.
  - `stall` high in cycles 0 and 1.
- SB, addr `0x2003`, `wdata` `0xAB`:
  - `dmem_we` = 1, `dmem_wmask` = `0x08`, `dmem_wdata[31:24]` = `0xAB`, `dmem_addr` = `0x2000`.
  - `load_valid` stays 0.
- LH at addr `0x1001`:
  - `misaligned` = 1 in that cycle.
  - No `dmem_req`, `stall` = 0.
- LBU, addr `0x3007`, `rdata` byte 7 = `0xF0`, ack delayed 5 cycles after `req`:
  - `load_data` = `0xF0`, zero-extended.
  - `stall` high for 7 cycles.
  - `dmem_addr` and `dmem_we` stable throughout REQ.
- `rst` pulsed mid-REQ:
  - `dmem_req` and `stall` go to 0 asynchronously.
  - A later LD at `0x4000` with `rdata` `0x0123456789ABCDEF` completes normally.
- Two consecutive LDs (`mem_valid` held):
  - Exactly two `dmem_req` transactions.
  - Second `req` rises 3 cycles after the first.
  - Two `load_valid` pulses.
